md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the P7 pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency, and mthi/mtlo as single-cycle writes; holds architectural HI/LO.
- Drives the start/busy pair the hazard logic uses to stall md-class instructions in D, and supplies HI/LO to the mfhi/mflo forwarding paths.

---
 rtl/md_unit.sv | 157 +++++++++++++++
 tb/tb_md_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency mult/multu/div/divu,
// single-cycle mthi/mtlo, and the architectural HI/LO registers.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        req,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_DIVU = 3'd4;
   localparam logic [2:0] OP_MTHI = 3'd5;
   localparam logic [2:0] OP_MTLO = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    op_reg;
   logic [31:0]   a_reg, b_reg;
   logic [31:0]   hi_reg, hi_next;
   logic [31:0]   lo_reg, lo_next;
   logic          load_ops;
   logic          finish;

   logic accept;
   logic is_long;
   logic is_mult;

   assign is_long = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
   assign is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
   assign accept  = start && !req && (state_reg == IDLE) &&
                    (md_op != OP_NONE) && (md_op != OP_RSVD);

   // Multiply: sign- or zero-extend to 64 bits; the low 64 product bits are
   // then correct for both signed and unsigned forms.
   logic        mul_signed;
   logic [63:0] mul_a, mul_b, prod;

   assign mul_signed = (op_reg == OP_MULT);
   assign mul_a = {{32{mul_signed & a_reg[31]}}, a_reg};
   assign mul_b = {{32{mul_signed & b_reg[31]}}, b_reg};
   assign prod  = mul_a * mul_b;

   // Divide on magnitudes with one unsigned divider, then fix signs: quotient
   // truncates toward zero, remainder follows the dividend. This also yields
   // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
   logic        div_signed, neg_a, neg_b, div_by_zero;
   logic [31:0] mag_a, mag_b, den, q_mag, r_mag, quot, rem;

   assign div_signed  = (op_reg == OP_DIV);
   assign neg_a       = div_signed & a_reg[31];
   assign neg_b       = div_signed & b_reg[31];
   assign mag_a       = neg_a ? (~a_reg + 32'd1) : a_reg;
   assign mag_b       = neg_b ? (~b_reg + 32'd1) : b_reg;
   assign div_by_zero = (b_reg == 32'd0);
   assign den         = div_by_zero ? 32'd1 : mag_b;
   assign q_mag       = mag_a / den;
   assign r_mag       = mag_a % den;
   assign quot        = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
   assign rem         = neg_a ? (~r_mag + 32'd1) : r_mag;

   // State register and architectural HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         op_reg    <= OP_NONE;
         a_reg     <= '0;
         b_reg     <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         if (load_ops) begin
            op_reg <= md_op;
            a_reg  <= rs_data;
            b_reg  <= rt_data;
         end
      end
   end

   // Next-state logic: the counter is loaded with N at accept and the result
   // commits on the edge where it reads 1, giving exactly N busy periods.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load_ops   = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept && is_long) begin
               state_next = RUN;
               load_ops   = 1'b1;
               cnt_next   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end
         end
         RUN: begin
            if (cnt_reg == CW'(1)) begin
               state_next = IDLE;
               cnt_next   = '0;
               finish     = 1'b1;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: HI/LO updates from mthi/mtlo or from a completing operation
   always_comb begin
      hi_next = hi_reg;
      lo_next = lo_reg;
      if (accept && (md_op == OP_MTHI)) hi_next = rs_data;
      if (accept && (md_op == OP_MTLO)) lo_next = rs_data;
      if (finish) begin
         case (op_reg)
            OP_MULT, OP_MULTU: begin
               hi_next = prod[63:32];
               lo_next = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
               if (!div_by_zero) begin
                  hi_next = rem;
                  lo_next = quot;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg == RUN);
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a table of arithmetic/move vectors checked cycle
// by cycle, plus hand sequences for ignored starts, back-to-back and reset.
module tb_md_unit;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_DIVU = 3'd4;
   localparam logic [2:0] OP_MTHI = 3'd5;
   localparam logic [2:0] OP_MTLO = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = OP_NONE;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        req = 1'b0;
   logic        busy;
   logic [31:0] hi, lo;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_data(rs_data), .rt_data(rt_data), .req(req),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          lat;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vec [10];

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] hi_exp = '0;
   logic [31:0] lo_exp = '0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Issue one op from idle, scramble operands while it runs, check busy and
   // HI/LO hold each cycle, then check the committed result.
   task automatic run_vec(input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      start   = 1'b1;
      md_op   = vec[idx].op;
      rs_data = vec[idx].rs;
      rt_data = vec[idx].rt;
      step();
      start   = 1'b0;
      md_op   = OP_NONE;
      rs_data = $urandom;
      rt_data = $urandom;
      for (int i = 0; i < vec[idx].lat; i++) begin
         chk({tag, " busy"}, {31'b0, busy}, 32'd1);
         chk({tag, " hi hold"}, hi, hi_exp);
         chk({tag, " lo hold"}, lo, lo_exp);
         step();
      end
      chk({tag, " busy done"}, {31'b0, busy}, 32'd0);
      chk({tag, " hi"}, hi, vec[idx].exp_hi);
      chk({tag, " lo"}, lo, vec[idx].exp_lo);
      hi_exp = vec[idx].exp_hi;
      lo_exp = vec[idx].exp_lo;
      $display("vec%0d op=%0d rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h", idx,
               vec[idx].op, vec[idx].rs, vec[idx].rt, hi, lo);
   endtask

   initial begin
      vec[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vec[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
      vec[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vec[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vec[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vec[5] = '{OP_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
      vec[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      vec[7] = '{OP_MTHI,  32'h12345678, 32'h0,        0,  32'h12345678, 32'hFFFFFFFD};
      vec[8] = '{OP_MTLO,  32'hCAFEBABE, 32'h0,        0,  32'h12345678, 32'hCAFEBABE};
      vec[9] = '{OP_MULT,  32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};

      step();
      step();
      reset = 1'b0;
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);

      for (int i = 0; i < 10; i++) run_vec(i);

      // mthi with req=1 is ignored
      start = 1'b1; md_op = OP_MTHI; rs_data = 32'hAAAAAAAA; req = 1'b1;
      step();
      chk("mthi req busy", {31'b0, busy}, 32'd0);
      chk("mthi req hi", hi, 32'h00000001);
      $display("mthi with req: hi=0x%08h", hi);

      // mult with req=1 is ignored
      md_op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
      step();
      chk("mult req busy", {31'b0, busy}, 32'd0);
      step();
      chk("mult req busy2", {31'b0, busy}, 32'd0);
      chk("mult req lo", lo, 32'h00000000);
      $display("mult with req: busy=%0b lo=0x%08h", busy, lo);

      // reserved op is ignored
      req = 1'b0; md_op = OP_RSVD;
      step();
      chk("rsvd busy", {31'b0, busy}, 32'd0);
      chk("rsvd hi", hi, 32'h00000001);
      chk("rsvd lo", lo, 32'h00000000);
      $display("op7: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

      // mtlo during a running mult is ignored
      md_op = OP_MULT; rs_data = 32'd3; rt_data = 32'd4;
      step();
      start = 1'b0; md_op = OP_NONE;
      step();
      start = 1'b1; md_op = OP_MTLO; rs_data = 32'hDEADBEEF;
      step();
      start = 1'b0; md_op = OP_NONE;
      chk("mtlo busy ignored", lo, 32'h00000000);
      step();
      step();
      chk("mult/mtlo busy last", {31'b0, busy}, 32'd1);
      step();
      chk("mult/mtlo busy done", {31'b0, busy}, 32'd0);
      chk("mult/mtlo hi", hi, 32'h00000000);
      chk("mult/mtlo lo", lo, 32'h0000000C);
      $display("mult 3*4 with mtlo in flight: hi=0x%08h lo=0x%08h", hi, lo);

      // start held at the completion edge is refused, accepted one edge later
      start = 1'b1; md_op = OP_MULT; rs_data = 32'd2; rt_data = 32'd5;
      step();
      start = 1'b0; md_op = OP_NONE;
      for (int i = 0; i < 4; i++) step();
      start = 1'b1; md_op = OP_MTHI; rs_data = 32'h00000055;
      step();
      chk("b2b busy done", {31'b0, busy}, 32'd0);
      chk("b2b hi at done", hi, 32'h00000000);
      chk("b2b lo at done", lo, 32'h0000000A);
      step();
      start = 1'b0; md_op = OP_NONE;
      chk("b2b hi next", hi, 32'h00000055);
      chk("b2b lo next", lo, 32'h0000000A);
      $display("back-to-back: hi=0x%08h lo=0x%08h", hi, lo);

      // reset mid-divide discards the result
      start = 1'b1; md_op = OP_DIV; rs_data = 32'd100; rt_data = 32'd3;
      step();
      start = 1'b0; md_op = OP_NONE;
      for (int i = 0; i < 3; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst mid busy", {31'b0, busy}, 32'd0);
      chk("rst mid hi", hi, 32'd0);
      chk("rst mid lo", lo, 32'd0);
      for (int i = 0; i < 8; i++) step();
      chk("rst late busy", {31'b0, busy}, 32'd0);
      chk("rst late hi", hi, 32'd0);
      chk("rst late lo", lo, 32'd0);
      $display("reset mid-div: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
